// File: rtl/core_seq.sv
// Instruction sequencer for core: per kernel position loads weights, streams
// activations, executes and drains the OFIFO, then accumulates/ReLUs each output pixel.
module core_seq #(
    parameter int          col        = 8,
    parameter int          len_kij    = 9,
    parameter int          len_nij    = 36,
    parameter int          len_onij   = 16,
    parameter int          i_width    = 6,
    parameter int          o_width    = 4,
    parameter logic [10:0] W_mem_base = 11'h400,
    parameter int          rst_cycles = 10,
    parameter int          gap_cycles = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [3:0]  out_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_WL0, S_LOAD, S_GAP, S_XL0, S_EXEC, S_DRAIN, S_ACC, S_RELU
    } state_t;

    localparam int          K_W       = 3;
    localparam logic [7:0]  RST_LAST  = 8'(rst_cycles - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(gap_cycles - 1);
    localparam logic [7:0]  COL_N     = 8'(col);
    localparam logic [7:0]  COL_LAST  = 8'(col - 1);
    localparam logic [7:0]  NIJ_N     = 8'(len_nij);
    localparam logic [7:0]  NIJ_LAST  = 8'(len_nij - 1);
    localparam logic [7:0]  KIJ_N     = 8'(len_kij);
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);
    localparam logic [3:0]  ONIJ_LAST = 4'(len_onij - 1);
    localparam logic [3:0]  OCOL_LAST = 4'(o_width - 1);
    localparam logic [1:0]  KJ_LAST   = 2'(K_W - 1);
    localparam logic [10:0] K_STEP    = 11'(len_nij + 1);
    localparam logic [10:0] K_ROW     = 11'(len_nij + i_width - (K_W - 1));
    localparam logic [10:0] P_ROW     = 11'(i_width - o_width + 1);
    localparam logic [34:0] INST_IDLE = {2'b00, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  kij, kij_n;
    logic [3:0]  onij, onij_n;
    logic [3:0]  ocol, ocol_n;
    logic [1:0]  kj, kj_n;
    logic        acc_phase, acc_phase_n;
    logic        gap_sel, gap_sel_n;
    logic        drain_rd, drain_rd_n;
    logic        drain_post, drain_post_n;
    logic [10:0] wptr, wptr_n;
    logic [10:0] koff, koff_n;
    logic [10:0] pix_base, pix_base_n;

    logic [34:0] inst_n;
    logic        core_rst_n, busy_n, done_n, out_valid_n;
    logic [3:0]  out_idx_n;

    logic        f_relu, f_acc, f_cen_p, f_wen_p, f_cen_x, f_wen_x;
    logic        f_ofifo_rd, f_l0_rd, f_l0_wr, f_exe, f_load;
    logic [10:0] f_a_p, f_a_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            kij        <= '0;
            onij       <= '0;
            ocol       <= '0;
            kj         <= '0;
            acc_phase  <= 1'b0;
            gap_sel    <= 1'b0;
            drain_rd   <= 1'b0;
            drain_post <= 1'b0;
            wptr       <= '0;
            koff       <= '0;
            pix_base   <= '0;
            inst       <= INST_IDLE;
            core_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            kij        <= kij_n;
            onij       <= onij_n;
            ocol       <= ocol_n;
            kj         <= kj_n;
            acc_phase  <= acc_phase_n;
            gap_sel    <= gap_sel_n;
            drain_rd   <= drain_rd_n;
            drain_post <= drain_post_n;
            wptr       <= wptr_n;
            koff       <= koff_n;
            pix_base   <= pix_base_n;
            inst       <= inst_n;
            core_rst   <= core_rst_n;
            busy       <= busy_n;
            done       <= done_n;
            out_valid  <= out_valid_n;
            out_idx    <= out_idx_n;
        end
    end

    // Outputs are decoded from the next-state values so they appear registered
    // in the same cycle the state register enters the corresponding state.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        kij_n        = kij;
        onij_n       = onij;
        ocol_n       = ocol;
        kj_n         = kj;
        acc_phase_n  = acc_phase;
        gap_sel_n    = gap_sel;
        drain_rd_n   = drain_rd;
        drain_post_n = drain_post;
        wptr_n       = wptr;
        koff_n       = koff;
        pix_base_n   = pix_base;
        done_n       = 1'b0;
        out_valid_n  = 1'b0;
        out_idx_n    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_RST;
                    cnt_n       = '0;
                    kij_n       = '0;
                    onij_n      = '0;
                    ocol_n      = '0;
                    acc_phase_n = 1'b0;
                    wptr_n      = '0;
                    pix_base_n  = '0;
                end
            end
            S_RST: begin
                if (cnt == RST_LAST) begin
                    cnt_n = '0;
                    if (acc_phase) begin
                        state_n = S_ACC;
                        koff_n  = '0;
                        kj_n    = '0;
                    end else begin
                        state_n = S_WL0;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_WL0: begin
                if (cnt == COL_N) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_LOAD: begin
                if (cnt == COL_LAST) begin
                    state_n   = S_GAP;
                    cnt_n     = '0;
                    gap_sel_n = 1'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (gap_sel) begin
                        state_n      = S_DRAIN;
                        drain_rd_n   = ofifo_valid;
                        drain_post_n = 1'b0;
                    end else begin
                        state_n = S_XL0;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_XL0: begin
                if (cnt == NIJ_N) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_EXEC: begin
                if (cnt == NIJ_LAST) begin
                    state_n   = S_GAP;
                    cnt_n     = '0;
                    gap_sel_n = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_DRAIN: begin
                // cnt is the word index; a due read waits in place while the OFIFO is empty
                if (drain_rd) begin
                    drain_rd_n   = 1'b0;
                    drain_post_n = 1'b1;
                    wptr_n       = wptr + 11'd1;
                end else if (drain_post) begin
                    drain_post_n = 1'b0;
                    if (cnt == NIJ_LAST) begin
                        cnt_n   = '0;
                        kij_n   = kij + 4'd1;
                        state_n = S_RST;
                        if (kij == KIJ_LAST) acc_phase_n = 1'b1;
                    end else begin
                        cnt_n      = cnt + 8'd1;
                        drain_rd_n = ofifo_valid;
                    end
                end else begin
                    drain_rd_n = ofifo_valid;
                end
            end
            S_ACC: begin
                if (cnt == KIJ_N) begin
                    state_n = S_RELU;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (kj == KJ_LAST) begin
                        kj_n   = '0;
                        koff_n = koff + K_ROW;
                    end else begin
                        kj_n   = kj + 2'd1;
                        koff_n = koff + K_STEP;
                    end
                end
            end
            S_RELU: begin
                out_valid_n = 1'b1;
                out_idx_n   = onij;
                if (onij == ONIJ_LAST) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    onij_n  = onij + 4'd1;
                    state_n = S_RST;
                    cnt_n   = '0;
                    if (ocol == OCOL_LAST) begin
                        ocol_n     = '0;
                        pix_base_n = pix_base + P_ROW;
                    end else begin
                        ocol_n     = ocol + 4'd1;
                        pix_base_n = pix_base + 11'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        f_relu     = 1'b0;
        f_acc      = 1'b0;
        f_cen_p    = 1'b1;
        f_wen_p    = 1'b1;
        f_a_p      = '0;
        f_cen_x    = 1'b1;
        f_wen_x    = 1'b1;
        f_a_x      = '0;
        f_ofifo_rd = 1'b0;
        f_l0_rd    = 1'b0;
        f_l0_wr    = 1'b0;
        f_exe      = 1'b0;
        f_load     = 1'b0;
        core_rst_n = 1'b0;

        case (state_n)
            S_RST: core_rst_n = 1'b1;
            S_WL0: begin
                if (cnt_n < COL_N) begin
                    f_cen_x = 1'b0;
                    f_a_x   = W_mem_base + 11'(cnt_n);
                end
                f_l0_wr = (cnt_n != '0);
            end
            S_LOAD: begin
                f_l0_rd = 1'b1;
                f_load  = 1'b1;
            end
            S_XL0: begin
                if (cnt_n < NIJ_N) begin
                    f_cen_x = 1'b0;
                    f_a_x   = 11'(cnt_n);
                end
                f_l0_wr = (cnt_n != '0);
            end
            S_EXEC: begin
                f_l0_rd = 1'b1;
                f_exe   = 1'b1;
            end
            S_DRAIN: begin
                if (drain_rd_n) begin
                    f_ofifo_rd = 1'b1;
                    f_cen_p    = 1'b0;
                    f_wen_p    = 1'b0;
                    f_a_p      = wptr_n;
                end
            end
            S_ACC: begin
                if (cnt_n < KIJ_N) begin
                    f_cen_p = 1'b0;
                    f_a_p   = pix_base_n + koff_n;
                end
                f_acc = (cnt_n != '0);
            end
            S_RELU: f_relu = 1'b1;
            default: ;
        endcase

        inst_n = {f_relu, f_acc, f_cen_p, f_wen_p, f_a_p, f_cen_x, f_wen_x, f_a_x,
                  f_ofifo_rd, 2'b00, f_l0_rd, f_l0_wr, f_exe, f_load};
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a queue of expected per-cycle outputs is built
// from the layer schedule and compared every cycle, with OFIFO stalls inserted on the fly.
module tb_core_seq;

    localparam int COL = 8, KIJ = 9, NIJ = 36, ONIJ = 16, IW = 6, OW = 4;
    localparam int WBASE = 1024, RSTC = 10, GAPC = 10;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [34:0] inst;
    logic        core_rst, busy, done, out_valid;
    logic [3:0]  out_idx;

    always #5 clk = ~clk;

    core_seq #(
        .col(COL), .len_kij(KIJ), .len_nij(NIJ), .len_onij(ONIJ),
        .i_width(IW), .o_width(OW), .W_mem_base(11'h400),
        .rst_cycles(RSTC), .gap_cycles(GAPC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .core_rst(core_rst), .busy(busy), .done(done),
        .out_valid(out_valid), .out_idx(out_idx)
    );

    typedef struct {
        logic [34:0] inst;
        bit          core_rst;
        bit          busy;
        bit          done;
        bit          out_valid;
        logic [3:0]  out_idx;
        bit          rd_due;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0, n_fail = 0;
    int          pos = 0, layers_started = 0;
    int          busy_cnt, ov_cnt, done_cnt, stalls;
    int          vmode = 0, stall_left = 0, want_rd_addr = -1;
    bit          stall_done = 0;
    bit          v_used = 1;
    logic [34:0] idle_w;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(input int relu, input int acc, input int pen, input int pwr,
                                       input int ap, input int xrd, input int ax, input int ofrd,
                                       input int l0rd, input int l0wr, input int exe, input int ld);
        return {relu != 0, acc != 0, pen == 0, pwr == 0, 11'(ap), xrd == 0, 1'b1, 11'(ax),
                ofrd != 0, 2'b00, l0rd != 0, l0wr != 0, exe != 0, ld != 0};
    endfunction

    task automatic push(input logic [34:0] i, input int crst, input int bsy, input int dn,
                        input int ov, input int idx, input int rd);
        exp_t e;
        e.inst = i; e.core_rst = (crst != 0); e.busy = (bsy != 0); e.done = (dn != 0);
        e.out_valid = (ov != 0); e.out_idx = 4'(idx); e.rd_due = (rd != 0);
        q.push_back(e);
    endtask

    task automatic build_layer();
        int a;
        q.delete();
        for (int k = 0; k < KIJ; k++) begin
            repeat (RSTC) push(idle_w, 1, 1, 0, 0, 0, 0);
            for (int t = 0; t <= COL; t++)
                push(mk(0, 0, 0, 0, 0, t < COL ? 1 : 0, t < COL ? WBASE + t : 0, 0, 0, t > 0 ? 1 : 0, 0, 0),
                     0, 1, 0, 0, 0, 0);
            repeat (COL) push(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), 0, 1, 0, 0, 0, 0);
            repeat (GAPC) push(idle_w, 0, 1, 0, 0, 0, 0);
            for (int t = 0; t <= NIJ; t++)
                push(mk(0, 0, 0, 0, 0, t < NIJ ? 1 : 0, t < NIJ ? t : 0, 0, 0, t > 0 ? 1 : 0, 0, 0),
                     0, 1, 0, 0, 0, 0);
            repeat (NIJ) push(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 0, 1, 0, 0, 0, 0);
            repeat (GAPC) push(idle_w, 0, 1, 0, 0, 0, 0);
            for (int w = 0; w < NIJ; w++) begin
                push(mk(0, 0, 1, 1, k * NIJ + w, 0, 0, 1, 0, 0, 0, 0), 0, 1, 0, 0, 0, 1);
                push(idle_w, 0, 1, 0, 0, 0, 0);
            end
        end
        for (int o = 0; o < ONIJ; o++) begin
            for (int r = 0; r < RSTC; r++)
                push(idle_w, 1, 1, 0, (r == 0 && o > 0) ? 1 : 0, (r == 0 && o > 0) ? o - 1 : 0, 0);
            for (int j = 0; j <= KIJ; j++) begin
                a = (j < KIJ) ? j * NIJ + (o / OW + j / 3) * IW + (o % OW) + (j % 3) : 0;
                push(mk(0, j > 0 ? 1 : 0, j < KIJ ? 1 : 0, 0, a, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0);
            end
            push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        end
        push(idle_w, 0, 0, 1, 1, ONIJ - 1, 0);
        layers_started++;
    endtask

    // One cycle: check this cycle's outputs, then drive inputs for the next edge.
    task automatic step(input int rst_i, input int st_i);
        exp_t e;
        int   val;
        @(negedge clk);
        if (q.size() == 0) begin
            e.inst = idle_w; e.core_rst = 0; e.busy = 0; e.done = 0;
            e.out_valid = 0; e.out_idx = '0; e.rd_due = 0;
        end else if (q[0].rd_due && !v_used) begin
            e = q[0];
            e.inst = idle_w;
            stalls++;
        end else begin
            e = q.pop_front();
            pos++;
        end
        check_eq($sformatf("trace[%0d]", pos),
                 64'({inst, core_rst, busy, done, out_valid, out_idx}),
                 64'({e.inst, e.core_rst, e.busy, e.done, e.out_valid, e.out_idx}));
        if (want_rd_addr >= 0 && inst[6] === 1'b1) begin
            check_eq("first_rd_addr", 64'(inst[30:20]), 64'(want_rd_addr));
            want_rd_addr = -1;
        end
        busy_cnt += (busy === 1'b1) ? 1 : 0;
        ov_cnt   += (out_valid === 1'b1) ? 1 : 0;
        done_cnt += (done === 1'b1) ? 1 : 0;

        case (vmode)
            1: begin
                if (pos == 510 && !stall_done) begin
                    stall_left   = 5;
                    stall_done   = 1;
                    want_rd_addr = 75;
                end
                val = (stall_left == 0) ? 1 : 0;
                if (stall_left > 0) stall_left--;
            end
            2: val = ($urandom_range(0, 3) != 0) ? 1 : 0;
            default: val = 1;
        endcase
        reset       = (rst_i != 0);
        start       = (st_i != 0);
        ofifo_valid = (val != 0);
        v_used      = (val != 0);
        if (rst_i != 0) q.delete();
        else if (!e.busy && st_i != 0) begin
            build_layer();
            pos = 0;
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0; ov_cnt = 0; done_cnt = 0; stalls = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        idle_w = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_counts();

        repeat (3) step(1, 0);
        check_eq("reset_inst", 64'(inst), 64'(35'h1_800C_0000));
        repeat (2) step(0, 0);

        // Layer 1: OFIFO always valid, exact cycle budget.
        clear_counts();
        step(0, 1);
        for (int c = 0; c < 6000 && q.size() > 0; c++) step(0, 0);
        check_eq("l1_drained", 64'(q.size()), 64'd0);
        check_eq("l1_busy", 64'(busy_cnt), 64'd2064);
        check_eq("l1_out_valid", 64'(ov_cnt), 64'd16);
        check_eq("l1_done", 64'(done_cnt), 64'd1);

        // Layer 2: 5-cycle OFIFO stall at kij=2 word 3; start held at the end.
        clear_counts();
        vmode = 1;
        step(0, 1);
        for (int c = 0; c < 6000 && layers_started == 2; c++) step(0, (q.size() <= 3) ? 1 : 0);
        check_eq("l2_restarted", 64'(layers_started), 64'd3);
        check_eq("l2_busy", 64'(busy_cnt), 64'd2069);
        check_eq("l2_out_valid", 64'(ov_cnt), 64'd16);
        check_eq("l2_done", 64'(done_cnt), 64'd1);
        check_eq("l2_first_rd_seen", 64'(want_rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);

        // Layer 3: reset during EXEC of kij=4.
        clear_counts();
        vmode = 0;
        for (int c = 0; c < 3000 && pos < 850; c++) step(0, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        check_eq("l3_busy_before_reset", 64'(busy_cnt), 64'd851);
        check_eq("l3_no_done", 64'(done_cnt), 64'd0);

        // Layer 4: random OFIFO gaps and stray start pulses while busy.
        clear_counts();
        vmode = 2;
        repeat ($urandom_range(1, 4)) step(0, 0);
        want_rd_addr = 0;
        step(0, 1);
        for (int c = 0; c < 9000 && q.size() > 0; c++) begin
            st = (q.size() > 5) ? int'($urandom_range(0, 1)) : 0;
            step(0, st);
        end
        check_eq("l4_drained", 64'(q.size()), 64'd0);
        check_eq("l4_busy", 64'(busy_cnt), 64'(2064 + stalls));
        check_eq("l4_out_valid", 64'(ov_cnt), 64'd16);
        check_eq("l4_done", 64'(done_cnt), 64'd1);
        vmode = 0;
        repeat (3) step(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
